mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: fetch (read-only) and data (load/store)
// share one synchronous single-port RAM through an IDLE/ACCESS/RESP FSM.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   if_req/if_addr    fetch request in; if_gnt, if_rvalid, if_rdata out
//   d_req/d_we/d_addr/d_wdata   data request in; d_gnt, d_rvalid, d_rdata out
//   ram_addr/ram_wdata/ram_wren registered RAM command out
//   ram_rdata         RAM read data in (one cycle after address)
//   busy              high whenever FSM is not in IDLE
//
// Build option: define MEM_ARBITER_RR_EN for round-robin tie breaking;
// otherwise the data port wins every tie.

module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_wren,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // owner_q: 1 = data port owns the transaction in flight
  logic owner_q;
  logic we_q;
  logic grant;
  logic pick_d;
  logic tie_to_d;

`ifdef MEM_ARBITER_RR_EN
  // 1 = data port received the most recent grant
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
    end else if (grant) begin
      last_q <= pick_d;
    end
  end

  assign tie_to_d = ~last_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // A lone requester always wins; only a tie consults the policy.
  assign pick_d = d_req & (~if_req | tie_to_d);

  assign busy = (state_q == ACCESS) || (state_q == RESP);

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    ram_wren  = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    unique case (state_q)
      ACCESS: begin
        ram_wren = we_q;
        state_d  = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (owner_q) begin
          d_rvalid = 1'b1;
          d_rdata  = ram_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = ram_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        // IDLE, and the unused encoding behaves as IDLE.
        // Grants are suppressed while reset is held.
        state_d = IDLE;
        if (!rst && (if_req || d_req)) begin
          grant   = 1'b1;
          d_gnt   = pick_d;
          if_gnt  = ~pick_d;
          state_d = ACCESS;
        end
      end
    endcase
  end

  // The RAM command registers double as the transaction latch:
  // loaded at grant, presented during ACCESS, held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q  <= pick_d;
        we_q     <= pick_d & d_we;
        ram_addr <= pick_d ? d_addr : if_addr;
        if (pick_d) begin
          ram_wdata <= d_wdata;
        end
      end
    end
  end

endmodule
